// File: rtl/param_seq_det.sv
// Parametrised serial sequence detector with run-time loadable pattern and saturating match count.
// Optional compare mask is enabled by defining SEQ_DET_MASK_EN.
module param_seq_det #(
    parameter int               PAT_W       = 4,
    parameter logic [PAT_W-1:0] DEFAULT_PAT = PAT_W'(4'b1011),
    parameter int               CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             seq_in,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pattern,
    input  logic             overlap,
    input  logic             clr_cnt,
`ifdef SEQ_DET_MASK_EN
    input  logic [PAT_W-1:0] mask,
`endif
    output logic             seq_out,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);

    localparam int               FILL_W   = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);
    localparam logic [FILL_W-1:0] FILL_THR = FILL_W'(PAT_W - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    logic [PAT_W-1:0]  pat_q,     pat_d;
    // Only the newest PAT_W-1 bits are kept; the oldest bit of a window is never needed again.
    logic [PAT_W-2:0]  hist_q,    hist_d;
    logic [FILL_W-1:0] fill_q,    fill_d;
    logic              seq_out_q, seq_out_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;
    logic              sat_q,     sat_d;
    logic [PAT_W-1:0]  cand;
    logic [PAT_W-1:0]  diff;
    logic              match;

`ifdef SEQ_DET_MASK_EN
    logic [PAT_W-1:0]  mask_q,    mask_d;
`endif

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        pat_d     = pat_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        seq_out_d = 1'b0;
        cnt_d     = cnt_q;
        sat_d     = sat_q;
`ifdef SEQ_DET_MASK_EN
        mask_d    = mask_q;
`endif

        cand = {hist_q, seq_in};
`ifdef SEQ_DET_MASK_EN
        diff = (cand ^ pat_q) & mask_q;
`else
        diff = cand ^ pat_q;
`endif
        // A load cycle discards its data bit, so it can never produce a match.
        match = en & ~pat_load & (fill_q >= FILL_THR) & (diff == '0);

        if (pat_load) begin
            pat_d  = pattern;
            fill_d = '0;
`ifdef SEQ_DET_MASK_EN
            mask_d = mask;
`endif
        end else if (en) begin
            hist_d    = cand[PAT_W-2:0];
            seq_out_d = match;
            if (match && !overlap) begin
                fill_d = '0;
            end else if (fill_q != FILL_MAX) begin
                fill_d = fill_q + FILL_W'(1);
            end
        end

        if (clr_cnt) begin
            cnt_d = '0;
            sat_d = 1'b0;
        end else if (match && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_d == CNT_MAX) begin
                sat_d = 1'b1;
            end
        end
    end

    // NOTE: reset is sampled on the clock edge only, so it is not in the sensitivity list.
    always_ff @(posedge clk) begin
        if (!reset) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            pat_q     <= DEFAULT_PAT;
            hist_q    <= '0;
            fill_q    <= '0;
            seq_out_q <= 1'b0;
            cnt_q     <= '0;
            sat_q     <= 1'b0;
`ifdef SEQ_DET_MASK_EN
            mask_q    <= '1;
`endif
        end else begin
            pat_q     <= pat_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            seq_out_q <= seq_out_d;
            cnt_q     <= cnt_d;
            sat_q     <= sat_d;
`ifdef SEQ_DET_MASK_EN
            mask_q    <= mask_d;
`endif
        end
    end

    assign seq_out   = seq_out_q;
    assign match_cnt = cnt_q;
    assign cnt_sat   = sat_q;

endmodule

// File: tb/tb_param_seq_det.sv
// Self-checking bench for param_seq_det: directed scenarios plus randomized traffic
// against a queue-based reference model; two instances with 8-bit and 2-bit counters.
module tb_param_seq_det;

    localparam int PAT_W = 4;
    localparam logic [PAT_W-1:0] DEF_PAT = 4'b1011;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset, en, seq_in, pat_load, overlap, clr_cnt;
    logic [PAT_W-1:0] pattern;
    logic             seq_out_a, cnt_sat_a, seq_out_b, cnt_sat_b;
    logic [7:0]       match_cnt_a;
    logic [1:0]       match_cnt_b;

    param_seq_det #(.PAT_W(PAT_W), .DEFAULT_PAT(DEF_PAT), .CNT_W(8)) dut_a (
        .clk(clk), .reset(reset), .en(en), .seq_in(seq_in), .pat_load(pat_load),
        .pattern(pattern), .overlap(overlap), .clr_cnt(clr_cnt),
        .seq_out(seq_out_a), .match_cnt(match_cnt_a), .cnt_sat(cnt_sat_a)
    );

    param_seq_det #(.PAT_W(PAT_W), .DEFAULT_PAT(DEF_PAT), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .en(en), .seq_in(seq_in), .pat_load(pat_load),
        .pattern(pattern), .overlap(overlap), .clr_cnt(clr_cnt),
        .seq_out(seq_out_b), .match_cnt(match_cnt_b), .cnt_sat(cnt_sat_b)
    );

    int checks   = 0;
    int failures = 0;
    int pulses   = 0;

    // Reference model: bits received since the last restart, newest at the back.
    bit               m_q[$];
    logic [PAT_W-1:0] m_pat = DEF_PAT;
    logic             e_out = 1'b0;
    int               e_cnt_a = 0, e_cnt_b = 0;
    logic             e_sat_a = 1'b0, e_sat_b = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_step();
        bit match = 1'b0;
        int n;
        if (!reset) begin
            m_pat = DEF_PAT;
            m_q.delete();
            e_out = 1'b0;
            e_cnt_a = 0; e_cnt_b = 0;
            e_sat_a = 1'b0; e_sat_b = 1'b0;
        end else begin
            if (pat_load) begin
                m_pat = pattern;
                m_q.delete();
                e_out = 1'b0;
            end else if (en) begin
                n = m_q.size();
                if (n >= PAT_W - 1) begin
                    match = (seq_in == m_pat[0]);
                    for (int i = 1; i < PAT_W; i++)
                        if (m_q[n-i] != m_pat[i]) match = 1'b0;
                end
                e_out = match;
                if (match && !overlap) m_q.delete();
                else begin
                    m_q.push_back(seq_in);
                    if (m_q.size() > PAT_W) void'(m_q.pop_front());
                end
            end else begin
                e_out = 1'b0;
            end
            if (clr_cnt) begin
                e_cnt_a = 0; e_cnt_b = 0;
                e_sat_a = 1'b0; e_sat_b = 1'b0;
            end else if (match) begin
                if (e_cnt_a < 255) e_cnt_a++;
                if (e_cnt_a == 255) e_sat_a = 1'b1;
                if (e_cnt_b < 3) e_cnt_b++;
                if (e_cnt_b == 3) e_sat_b = 1'b1;
            end
        end
    endtask

    task automatic cyc(input logic e, input logic s, input logic pl = 1'b0,
                       input logic [PAT_W-1:0] p = '0, input logic ov = 1'b1,
                       input logic cc = 1'b0, input logic r = 1'b1);
        @(negedge clk);
        reset = r; en = e; seq_in = s; pat_load = pl;
        pattern = p; overlap = ov; clr_cnt = cc;
        model_step();
        @(posedge clk);
        #1;
        check("seq_out_a",   32'(seq_out_a),   32'(e_out));
        check("match_cnt_a", 32'(match_cnt_a), 32'(e_cnt_a));
        check("cnt_sat_a",   32'(cnt_sat_a),   32'(e_sat_a));
        check("seq_out_b",   32'(seq_out_b),   32'(e_out));
        check("match_cnt_b", 32'(match_cnt_b), 32'(e_cnt_b));
        check("cnt_sat_b",   32'(cnt_sat_b),   32'(e_sat_b));
        if (seq_out_a === 1'b1) pulses++;
    endtask

    task automatic do_reset();
        cyc(1'b0, 1'b0, .r(1'b0));
        pulses = 0;
    endtask

    logic stream7 [7]   = '{1, 0, 1, 1, 0, 1, 1};
    logic ovl_exp [7]   = '{0, 0, 0, 1, 0, 0, 1};
    logic bits4   [4]   = '{1, 0, 1, 1};
    logic load4   [4]   = '{0, 1, 1, 0};

    initial begin
        reset = 1'b0; en = 1'b0; seq_in = 1'b0; pat_load = 1'b0;
        pattern = '0; overlap = 1'b1; clr_cnt = 1'b0;

        // Reset state.
        do_reset();
        do_reset();
        check("rst_seq_out", 32'(seq_out_a), 32'd0);
        check("rst_cnt",     32'(match_cnt_a), 32'd0);

        // Overlapping detection of 1011 in 1011011.
        for (int i = 0; i < 7; i++) begin
            cyc(1'b1, stream7[i]);
            check("ovl_pulse", 32'(seq_out_a), 32'(ovl_exp[i]));
        end
        check("ovl_cnt", 32'(match_cnt_a), 32'd2);

        // Non-overlapping: only the first match.
        do_reset();
        for (int i = 0; i < 7; i++) cyc(1'b1, stream7[i], .ov(1'b0));
        check("novl_pulses", 32'(pulses), 32'd1);
        check("novl_cnt",    32'(match_cnt_a), 32'd1);

        // Qualifier gaps between every bit.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, bits4[i]);
            if (i == 3) check("gap_pulse", 32'(seq_out_a), 32'd1);
            cyc(1'b0, ~bits4[i]);
        end
        check("gap_pulses", 32'(pulses), 32'd1);
        check("gap_after",  32'(seq_out_a), 32'd0);

        // Runtime load after a partial prefix; the load-cycle bit is discarded.
        do_reset();
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b1, .pl(1'b1), .p(4'b0110));
        check("load_no_pulse", 32'(seq_out_a), 32'd0);
        for (int i = 0; i < 4; i++) cyc(1'b1, load4[i]);
        check("load_pulse",  32'(seq_out_a), 32'd1);
        check("load_pulses", 32'(pulses), 32'd1);

        // Reset mid-pattern aborts the partial match.
        do_reset();
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b1);
        do_reset();
        cyc(1'b1, 1'b1);
        check("abort_no_pulse", 32'(seq_out_a), 32'd0);

        // Reset wins over pat_load: default pattern still detected.
        cyc(1'b0, 1'b0, .pl(1'b1), .p(4'b0000), .r(1'b0));
        pulses = 0;
        for (int i = 0; i < 4; i++) cyc(1'b1, bits4[i]);
        check("rst_load_pulse", 32'(seq_out_a), 32'd1);

        // Saturation of the 2-bit counter after five overlapping matches.
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1'b1, bits4[i]);
        for (int k = 0; k < 4; k++) begin
            cyc(1'b1, 1'b0);
            cyc(1'b1, 1'b1);
            cyc(1'b1, 1'b1);
        end
        check("sat_cnt_a", 32'(match_cnt_a), 32'd5);
        check("sat_cnt_b", 32'(match_cnt_b), 32'd3);
        check("sat_flag_b", 32'(cnt_sat_b), 32'd1);

        // Clear coincident with a match: clear wins, pulse still happens.
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b1, .cc(1'b1));
        check("clr_pulse",  32'(seq_out_b), 32'd1);
        check("clr_cnt_b",  32'(match_cnt_b), 32'd0);
        check("clr_sat_b",  32'(cnt_sat_b), 32'd0);
        check("clr_cnt_a",  32'(match_cnt_a), 32'd0);

        // Randomized traffic against the reference model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 9) < 8), 1'($urandom),
                ($urandom_range(0, 49) == 0), PAT_W'($urandom),
                1'($urandom), ($urandom_range(0, 99) < 2),
                ($urandom_range(0, 199) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
